// File: rtl/dbg_pkg.sv
// Shared types and constants for the register-file dump readout.
// State encoding, sync byte and register-file geometry.
package dbg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [7:0] HEADER_DEF = 8'hA5;
  localparam int NUM_REGS = 32;
  localparam int BYTES_PER_REG = 4;
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int SEL_W = $clog2(BYTES_PER_REG);

  // Byte order is MSB first: sel 0 -> [31:24]
  function automatic logic [7:0] pick_byte(
    input logic [31:0] w,
    input logic [1:0]  sel
  );
    logic [7:0] b;
    b = w[31:24];
    unique case (sel)
      2'd0: b = w[31:24];
      2'd1: b = w[23:16];
      2'd2: b = w[15:8];
      2'd3: b = w[7:0];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/regfile_dump_tx_if.sv
// Host-facing bundle of the dump block: request/status, read port, UART line.
// master = requester and register file, slave = dump block.
interface regfile_dump_tx_if;
  logic        dump_start;
  logic [4:0]  reg_index;
  logic [31:0] reg_data;
  logic        tx;
  logic        busy;
  logic        done;

  modport master (
    output dump_start,
    output reg_data,
    input  reg_index,
    input  tx,
    input  busy,
    input  done
  );

  modport slave (
    input  dump_start,
    input  reg_data,
    output reg_index,
    output tx,
    output busy,
    output done
  );
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serialiser: START, 8 data bits LSB first, STOP.
// Accepts a byte via load_i while ready_o; last_o marks the final stop cycle.
module uart_tx_byte
  import dbg_pkg::*;
#(
  parameter int BAUD_DIV = 10416
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  output logic       ready_o,
  output logic       last_o,
  output logic       tx_o
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  state_t        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic          baud_last;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
    end
  end

  assign baud_last = (baud_q == BAUD_LAST);
  assign ready_o   = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    tx_o    = 1'b1;
    last_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (load_i) begin
          shift_d = byte_i;
          state_d = START;
        end
      end
      START: begin
        tx_o = 1'b0;
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        tx_o = shift_q[0];
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          last_o  = 1'b1;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/regfile_dump_tx.sv
// Register-file dump over UART: header byte then 32 registers, MSB first.
// Sequences word/byte selection and hands each byte to uart_tx_byte.
module regfile_dump_tx
  import dbg_pkg::*;
#(
  parameter int         BAUD_DIV = 10416,
  parameter logic [7:0] HEADER   = HEADER_DEF
) (
  input  logic             clock,
  input  logic             reset,
  regfile_dump_tx_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(BYTES_PER_REG - 1);

  // START here covers the whole span owned by the serialiser
  state_t           seq_q, seq_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic [SEL_W-1:0] byte_sel_q, byte_sel_d;
  logic [31:0]      latch_q, latch_d;
  logic             hdr_pend_q, hdr_pend_d;
  logic             hdr_cur_q, hdr_cur_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic        load;
  logic        ready;
  logic        last;
  logic        tx;
  logic [31:0] src;
  logic [7:0]  tx_byte;

  uart_tx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_ser (
    .clock  (clock),
    .reset  (reset),
    .load_i (load),
    .byte_i (tx_byte),
    .ready_o(ready),
    .last_o (last),
    .tx_o   (tx)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      seq_q      <= IDLE;
      word_idx_q <= '0;
      byte_sel_q <= '0;
      latch_q    <= '0;
      hdr_pend_q <= 1'b0;
      hdr_cur_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      seq_q      <= seq_d;
      word_idx_q <= word_idx_d;
      byte_sel_q <= byte_sel_d;
      latch_q    <= latch_d;
      hdr_pend_q <= hdr_pend_d;
      hdr_cur_q  <= hdr_cur_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // First byte of a word comes straight from the read port
  assign src     = (byte_sel_q == '0) ? bus.reg_data : latch_q;
  assign tx_byte = hdr_pend_q ? HEADER : pick_byte(src, byte_sel_q);

  always_comb begin
    seq_d      = seq_q;
    word_idx_d = word_idx_q;
    byte_sel_d = byte_sel_q;
    latch_d    = latch_q;
    hdr_pend_d = hdr_pend_q;
    hdr_cur_d  = hdr_cur_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    load       = 1'b0;
    unique case (seq_q)
      IDLE: begin
        if (bus.dump_start) begin
          seq_d      = LOAD;
          busy_d     = 1'b1;
          hdr_pend_d = 1'b1;
          word_idx_d = '0;
          byte_sel_d = '0;
        end
      end
      LOAD: begin
        load = 1'b1;
        if (ready) begin
          seq_d      = START;
          hdr_cur_d  = hdr_pend_q;
          hdr_pend_d = 1'b0;
          if (!hdr_pend_q && byte_sel_q == '0) begin
            latch_d = bus.reg_data;
          end
        end
      end
      START: begin
        if (last) begin
          if (hdr_cur_q) begin
            seq_d = LOAD;
          end else if (byte_sel_q == LAST_SEL &&
                       word_idx_q == LAST_IDX) begin
            seq_d  = IDLE;
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            byte_sel_d = byte_sel_q + SEL_W'(1);
            if (byte_sel_q == LAST_SEL) begin
              word_idx_d = word_idx_q + IDX_W'(1);
            end
            seq_d = LOAD;
          end
        end
      end
      default: seq_d = IDLE;
    endcase
  end

  assign bus.reg_index = word_idx_q;
  assign bus.tx        = tx;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_regfile_dump_tx.sv
// Bench for regfile_dump_tx: UART monitor against a byte scoreboard,
// frame timing, tear-free capture, retrigger and mid-dump reset.
module tb_regfile_dump_tx;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  regfile_dump_tx_if b4();
  regfile_dump_tx_if b2();

  logic [31:0] regs [32];
  assign b4.reg_data = regs[b4.reg_index];
  assign b2.reg_data = regs[b2.reg_index];

  regfile_dump_tx #(
    .BAUD_DIV(4),
    .HEADER  (8'hA5)
  ) dut4 (
    .clock(clock),
    .reset(reset),
    .bus  (b4)
  );

  regfile_dump_tx #(
    .BAUD_DIV(2),
    .HEADER  (8'hA5)
  ) dut2 (
    .clock(clock),
    .reset(reset),
    .bus  (b2)
  );

  int checks = 0;
  int errors = 0;
  int rx4 = 0;
  int rx2 = 0;
  bit abort4 = 1'b0;
  logic [7:0] q4 [$];
  logic [7:0] q2 [$];

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic tx_of(input int d);
    return (d == 2) ? b2.tx : b4.tx;
  endfunction

  function automatic logic busy_of(input int d);
    return (d == 2) ? b2.busy : b4.busy;
  endfunction

  function automatic logic done_of(input int d);
    return (d == 2) ? b2.done : b4.done;
  endfunction

  task automatic set_start(input int d, input logic v);
    if (d == 2) b2.dump_start = v;
    else b4.dump_start = v;
  endtask

  task automatic push_b(input int d, input logic [7:0] b);
    if (d == 2) q2.push_back(b);
    else q4.push_back(b);
  endtask

  task automatic push_dump(input int d);
    logic [31:0] w;
    push_b(d, 8'hA5);
    for (int k = 0; k < 32; k++) begin
      w = regs[k];
      for (int j = 0; j < 4; j++) begin
        push_b(d, w[8*(3-j) +: 8]);
      end
    end
  endtask

  task automatic sb_cmp(input int d, input logic [7:0] b);
    if (d == 2) begin
      rx2++;
      if (q2.size() > 0) chk("byte_d2", 64'(b), 64'(q2.pop_front()));
      else chk("extra_d2", 64'(b), 64'h100);
    end else begin
      rx4++;
      if (q4.size() > 0) chk("byte_d4", 64'(b), 64'(q4.pop_front()));
      else chk("extra_d4", 64'(b), 64'h100);
    end
  endtask

  task automatic mon(input int d);
    logic [7:0] b;
    logic stp;
    forever begin
      @(negedge clock);
      if (tx_of(d) === 1'b0) begin
        repeat (d / 2) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
          repeat (d) @(negedge clock);
          b[i] = tx_of(d);
        end
        repeat (d) @(negedge clock);
        stp = tx_of(d);
        if (d == 4 && abort4) begin
          abort4 = 1'b0;
          q4.delete();
        end else begin
          chk("stop_bit", 64'(stp), 64'd1);
          sb_cmp(d, b);
        end
      end
    end
  endtask

  initial mon(4);
  initial mon(2);

  function automatic logic [40:0] hdr_frame(input logic [7:0] h);
    logic [40:0] v;
    v = '1;
    v[4:1] = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < 4; c++) v[5 + 4*i + c] = h[i];
    end
    return v;
  endfunction

  // n=0 is the LOAD cycle; returns at the done cycle or on timeout
  task automatic run_dump(
    input  int          d,
    input  bit          hold,
    input  int          tear_at,
    output int          done_at,
    output int          busy_low,
    output logic [40:0] txv
  );
    int lim;
    lim = 129 * (10 * d + 1) + 20;
    done_at = -1;
    busy_low = 0;
    txv = '0;
    push_dump(d);
    set_start(d, 1'b1);
    @(negedge clock);
    if (!hold) set_start(d, 1'b0);
    for (int n = 0; n < lim; n++) begin
      if (n == tear_at) regs[5] = 32'h12345678;
      if (n < 41) txv[n] = tx_of(d);
      if (done_of(d)) begin
        done_at = n;
        break;
      end
      if (!busy_of(d)) busy_low++;
      @(negedge clock);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int da, bl, base, dc;
    logic [40:0] tv;
    for (int k = 0; k < 32; k++) regs[k] = 32'(32'h01010101 * k);
    b4.dump_start = 1'b0;
    b2.dump_start = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_tx", 64'(b4.tx), 64'd1);
    chk("rst_busy", 64'(b4.busy), 64'd0);
    chk("rst_done", 64'(b4.done), 64'd0);
    chk("rst_idx", 64'(b4.reg_index), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // basic dump with frame timing
    base = rx4;
    run_dump(4, 1'b0, -1, da, bl, tv);
    chk("hdr_frame", 64'(tv), 64'(hdr_frame(8'hA5)));
    chk("done_at", 64'(da), 64'(129 * 41));
    chk("busy_hold", 64'(bl), 64'd0);
    @(negedge clock);
    chk("done_width", 64'(b4.done), 64'd0);
    chk("busy_end", 64'(b4.busy), 64'd0);
    chk("bytes_a", 64'(rx4 - base), 64'd129);
    chk("drain_a", 64'(q4.size()), 64'd0);

    // tear-free capture with dump_start held throughout
    regs[5] = 32'hDEADBEEF;
    base = rx4;
    run_dump(4, 1'b1, 21 * 41 + 1, da, bl, tv);
    chk("done_at_b", 64'(da), 64'(129 * 41));
    chk("busy_hold_b", 64'(bl), 64'd0);
    chk("bytes_b", 64'(rx4 - base), 64'd129);
    chk("drain_b", 64'(q4.size()), 64'd0);
    push_dump(4);
    @(negedge clock);
    chk("retrig_load", 64'(b4.busy), 64'd1);
    set_start(4, 1'b0);

    // reset during the data bits of byte 40
    base = rx4;
    repeat (40 * 41 + 15) @(negedge clock);
    abort4 = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    chk("mid_tx", 64'(b4.tx), 64'd1);
    chk("mid_busy", 64'(b4.busy), 64'd0);
    chk("mid_idx", 64'(b4.reg_index), 64'd0);
    chk("mid_done", 64'(b4.done), 64'd0);
    reset = 1'b0;
    dc = 0;
    repeat (200) begin
      @(negedge clock);
      if (b4.done) dc++;
    end
    chk("no_done", 64'(dc), 64'd0);
    chk("bytes_c", 64'(rx4 - base), 64'd40);
    chk("flush_c", 64'(q4.size()), 64'd0);

    // restart after reset begins with the header
    regs[5] = 32'h05050505;
    base = rx4;
    run_dump(4, 1'b0, -1, da, bl, tv);
    chk("restart_hdr", 64'(tv), 64'(hdr_frame(8'hA5)));
    chk("done_at_d", 64'(da), 64'(129 * 41));
    @(negedge clock);
    chk("bytes_d", 64'(rx4 - base), 64'd129);

    // minimum divisor
    base = rx2;
    run_dump(2, 1'b0, -1, da, bl, tv);
    chk("done_at_e", 64'(da), 64'(129 * 21));
    chk("busy_hold_e", 64'(bl), 64'd0);
    @(negedge clock);
    chk("done_width_e", 64'(b2.done), 64'd0);
    chk("bytes_e", 64'(rx2 - base), 64'd129);
    chk("drain_e", 64'(q2.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
